// File: rtl/button_event_queue.sv
// Button front end: per-button synchroniser + debouncer feeding a 4-deep press-event FIFO.
// The CPU reads the head through evt_out and pops it on a rising edge of ack.

module button_debounce #(
    parameter int DEB_CYCLES = 50000,
    parameter int DEB_W      = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);
    logic [1:0]       r_sync;
    logic [1:0]       r_vld;
    logic [DEB_W-1:0] r_cnt;
    logic             r_level;
    logic             r_armed;
    logic [DEB_W-1:0] w_cnt_inc;
    logic             w_flip;

    assign w_cnt_inc = r_cnt + DEB_W'(1);
    assign w_flip    = (r_sync[1] != r_level) && (w_cnt_inc == DEB_W'(DEB_CYCLES));

    // A button held through reset stays unarmed until the synchroniser sees it released,
    // so the first debounced rise after reset cannot turn into an event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync  <= '0;
            r_vld   <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_vld   <= {r_vld[0], 1'b1};
            r_armed <= r_armed | (r_vld[1] & ~r_sync[1]);
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_cnt   <= '0;
                r_level <= ~r_level;
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = w_flip & ~r_level & r_armed;
endmodule

module button_event_queue #(
    parameter int DEB_CYCLES = 50000,
    parameter int DEB_W      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       ack,
    output logic [7:0] evt_out,
    output logic [3:0] btn_level
);
    logic [3:0]      w_press;
    logic [3:0]      r_pending;
    logic [3:0]      w_clr;
    logic [1:0]      w_code;
    logic            w_push;
    logic            w_pop;
    logic            w_write;
    logic            w_ovf_set;
    logic            w_valid;
    logic            r_ack_d;
    logic [3:0][1:0] r_mem;
    logic [1:0]      r_wp;
    logic [1:0]      r_rp;
    logic [2:0]      r_count;
    logic            r_ovf;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb (
            .clk     (clk),
            .reset   (reset),
            .i_btn   (btn[i]),
            .o_level (btn_level[i]),
            .o_press (w_press[i])
        );
    end

    // Lowest-index pending press wins the single push slot each cycle.
    always_comb begin
        w_code = 2'd0;
        w_clr  = 4'b0000;
        if (r_pending[0])      begin w_code = 2'd0; w_clr = 4'b0001; end
        else if (r_pending[1]) begin w_code = 2'd1; w_clr = 4'b0010; end
        else if (r_pending[2]) begin w_code = 2'd2; w_clr = 4'b0100; end
        else if (r_pending[3]) begin w_code = 2'd3; w_clr = 4'b1000; end
    end

    assign w_push    = |r_pending;
    assign w_valid   = (r_count != 3'd0);
    assign w_pop     = ack & ~r_ack_d & w_valid;
    assign w_write   = w_push & ((r_count != 3'd4) | w_pop);
    assign w_ovf_set = w_push & (r_count == 3'd4) & ~w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
            r_ack_d   <= 1'b0;
            r_mem     <= '0;
            r_wp      <= '0;
            r_rp      <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_press;
            r_ack_d   <= ack;
            if (w_write) begin
                r_mem[r_wp] <= w_code;
                r_wp        <= r_wp + 2'd1;
            end
            if (w_pop) r_rp <= r_rp + 2'd1;
            r_count <= r_count + {2'b00, w_write} - {2'b00, w_pop};
            if (w_ovf_set)  r_ovf <= 1'b1;
            else if (w_pop) r_ovf <= 1'b0;
        end
    end

    assign evt_out = {w_valid, r_ovf, r_count, 1'b0, (w_valid ? r_mem[r_rp] : 2'b00)};
endmodule

// File: tb/tb_button_event_queue.sv
// Directed bench for button_event_queue with DEB_CYCLES=4: a vector table walked in a loop
// plus hand-written reset sequences.

module tb_button_event_queue;
    logic       clk;
    logic       reset;
    logic [3:0] btn;
    logic       ack;
    logic [7:0] evt_out;
    logic [3:0] btn_level;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] b;
        logic       a;
        int         cyc;
        logic [7:0] evt;
        logic [3:0] lvl;
    } vec_t;

    vec_t vecs[$];

    button_event_queue #(.DEB_CYCLES(4), .DEB_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .ack       (ack),
        .evt_out   (evt_out),
        .btn_level (btn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic [3:0] b, input logic a, input int cyc,
                       input logic [7:0] e, input logic [3:0] l);
        vec_t v;
        v.b = b; v.a = a; v.cyc = cyc; v.evt = e; v.lvl = l;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] e, input logic [3:0] l);
        n_checks++;
        if (evt_out !== e) begin
            n_errors++;
            $display("FAIL %s evt_out: got %02h want %02h", name, evt_out, e);
        end
        n_checks++;
        if (btn_level !== l) begin
            n_errors++;
            $display("FAIL %s btn_level: got %04b want %04b", name, btn_level, l);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // single press of button 2, pop, hold ack, release
        add(4'b0100, 0, 5, 8'h00, 4'b0000);
        add(4'b0100, 0, 1, 8'h00, 4'b0100);
        add(4'b0100, 0, 1, 8'h8A, 4'b0100);
        add(4'b0100, 1, 1, 8'h00, 4'b0100);
        add(4'b0100, 1, 3, 8'h00, 4'b0100);
        add(4'b0000, 0, 6, 8'h00, 4'b0000);
        // bounce rejection then a solid press of button 0
        add(4'b0001, 0, 3, 8'h00, 4'b0000);
        add(4'b0000, 0, 3, 8'h00, 4'b0000);
        add(4'b0001, 0, 3, 8'h00, 4'b0000);
        add(4'b0000, 0, 3, 8'h00, 4'b0000);
        add(4'b0001, 0, 10, 8'h88, 4'b0001);
        add(4'b0001, 1, 1, 8'h00, 4'b0001);
        add(4'b0000, 0, 6, 8'h00, 4'b0000);
        // simultaneous press of buttons 0 and 3
        add(4'b1001, 0, 6, 8'h00, 4'b1001);
        add(4'b1001, 0, 1, 8'h88, 4'b1001);
        add(4'b1001, 0, 1, 8'h90, 4'b1001);
        add(4'b1001, 1, 1, 8'h8B, 4'b1001);
        add(4'b0000, 0, 6, 8'h8B, 4'b0000);
        add(4'b0000, 1, 1, 8'h00, 4'b0000);
        add(4'b0000, 0, 1, 8'h00, 4'b0000);
        // fill to 4, fifth press dropped with overflow
        add(4'b0111, 0, 6, 8'h00, 4'b0111);
        add(4'b0111, 0, 3, 8'h98, 4'b0111);
        add(4'b1000, 0, 6, 8'h98, 4'b1000);
        add(4'b1000, 0, 1, 8'hA0, 4'b1000);
        add(4'b0001, 0, 6, 8'hA0, 4'b0001);
        add(4'b0001, 0, 1, 8'hE0, 4'b0001);
        // push coincident with pop while full: count stays 4, overflow clears
        add(4'b0010, 0, 6, 8'hE0, 4'b0010);
        add(4'b0010, 1, 1, 8'hA1, 4'b0010);
        add(4'b0010, 0, 1, 8'hA1, 4'b0010);
        add(4'b0010, 1, 1, 8'h9A, 4'b0010);
        add(4'b0000, 0, 6, 8'h9A, 4'b0000);
        add(4'b0000, 1, 1, 8'h93, 4'b0000);
        add(4'b0000, 0, 1, 8'h93, 4'b0000);
        add(4'b0000, 1, 1, 8'h89, 4'b0000);
        add(4'b0000, 0, 1, 8'h89, 4'b0000);
        add(4'b0000, 1, 1, 8'h00, 4'b0000);
        add(4'b0000, 0, 1, 8'h00, 4'b0000);
        // pop on empty is ignored, then a press reads back cleanly
        add(4'b0000, 1, 1, 8'h00, 4'b0000);
        add(4'b0000, 0, 1, 8'h00, 4'b0000);
        add(4'b0100, 0, 7, 8'h8A, 4'b0100);
        add(4'b0100, 1, 1, 8'h00, 4'b0100);
        add(4'b0000, 0, 6, 8'h00, 4'b0000);

        btn = 4'b0000; ack = 1'b0; reset = 1'b0;
        cycles(2);
        check("reset_state", 8'h00, 4'b0000);
        reset = 1'b1;
        cycles(4);

        foreach (vecs[k]) begin
            btn = vecs[k].b;
            ack = vecs[k].a;
            cycles(vecs[k].cyc);
            check($sformatf("vec%0d", k), vecs[k].evt, vecs[k].lvl);
        end

        // reset mid-run with a non-empty FIFO, button 1 held through release
        btn = 4'b0100; ack = 1'b0;
        cycles(7);
        check("pre_reset", 8'h8A, 4'b0100);
        btn = 4'b0010;
        reset = 1'b0;
        #1;
        check("async_reset", 8'h00, 4'b0000);
        cycles(1);
        reset = 1'b1;
        cycles(6);
        check("held_level", 8'h00, 4'b0010);
        cycles(3);
        check("held_no_evt", 8'h00, 4'b0010);
        btn = 4'b0000;
        cycles(6);
        check("held_release", 8'h00, 4'b0000);
        btn = 4'b0010;
        cycles(7);
        check("repress_evt", 8'h89, 4'b0010);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/button_event_queue.md
Name: button_event_queue

Overview:
- Input-side peripheral that turns the four raw game buttons into a queued event byte that the CPU reads on its `ent1` data input.
- Each button is synchronised and debounced, and its press edge is detected. Press events are pushed into a 4-deep FIFO.
- The CPU acknowledges an event by toggling one bit of its `sal` output, which is wired to `ack`; the rising edge pops the head entry.
- This decouples human-speed button presses from the single-cycle CPU's polling loop.

Parameters:
- DEB_CYCLES, 50000, consecutive cycles a synchronised input must differ from the debounced level before that level flips (legal range 1..65535).
- DEB_W, 16, width of each debounce counter; must hold DEB_CYCLES.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- btn  input  4  raw button levels, 1 = pressed, asynchronous to clk
- ack  input  1  pop request from CPU output register, clk domain, level; the rising edge pops
- evt_out  output  8  event byte: [7] valid (FIFO not empty), [6] overflow sticky, [5:3] count 0..4, [2] 0, [1:0] head button code (00 when empty)
- btn_level  output  4  debounced button levels

Behaviour:
- Reset (reset=0, asynchronous):
  - Sync flops, debounce counters, `btn_level`, pending bits, FIFO pointers/count, overflow flag and `ack_d` all clear to 0.
  - `evt_out` = 8'h00.
  - Reset mid-debounce or with a non-empty FIFO discards everything. No event is generated for a button already held when reset releases until it is released and pressed again.
- Synchroniser: two flops per button, `btn_s[i]` = `btn[i]` delayed 2 cycles.
- Debounce, per button:
  - If `btn_s[i]` == `btn_level[i]`, the counter is cleared to 0.
  - Otherwise the counter increments. When it would reach DEB_CYCLES, `btn_level[i]` toggles and the counter clears on that same edge.
  - Glitches shorter than DEB_CYCLES produce no change.
  - Latency from a clean `btn` edge to `btn_level` change is 2+DEB_CYCLES cycles.
- Press detect:
  - On the edge where `btn_level[i]` goes 0->1, `pending[i]` is set.
  - Release (1->0) generates nothing.
- Push arbitration:
  - Each cycle at most one push occurs: the lowest-index set pending bit is written (code = index) and that pending bit is cleared.
  - A pending bit that is set again while still set stays a single event.
  - Result: simultaneous presses enqueue in index order on consecutive cycles.
- Pop: `ack_d` <= `ack` every cycle. A pop occurs when `ack`=1 and `ack_d`=0, and only if count>0; a pop on an empty FIFO is ignored.
- FIFO: depth 4, 2-bit wrapping read/write pointers, 3-bit count.
  - Push when count=4 and no pop in the same cycle: the entry is dropped, pending is still cleared, and overflow is set.
  - Push and pop in the same cycle: both are performed, count is unchanged, and this is legal when full.
  - Push and pop in the same cycle with count=0: the push is performed, the pop is ignored, and count becomes 1.
- Overflow flag: sticky. It is cleared on any performed pop; a simultaneous overflowing push wins and keeps it set.
- `evt_out` is registered/combinational from FIFO state only; it never depends on `btn` combinationally.
- An event pushed at edge E is visible on `evt_out` after E, with `valid`=1 and `count` incremented.

Test Plan (DEB_CYCLES=4):
- Reset behaviour: assert reset=0 mid-run -> `evt_out`=00, `btn_level`=0 immediately. Release reset with `btn`=4'b0010 held -> `btn_level[1]`=1 after 6 cycles, but no event (`evt_out` stays 00). Then release and press `btn[1]` -> event appears.
- Single press: hold `btn[2]`=1 -> `btn_level[2]`=1 after 6 cycles, next cycle `evt_out`=8'h8A (valid, count 1, code 2). Pulse `ack` 0->1 -> `evt_out`=8'h00 the cycle after. Holding `ack` high produces no further pops.
- Bounce rejection: toggle `btn[0]` with pulses of 3 cycles -> `btn_level` never changes and `evt_out` stays 00. Then hold 10 cycles -> exactly one event, code 0 (`evt_out`=8'h88).
- Simultaneous press: `btn`=4'b1001 raised together -> two pushes on consecutive cycles. `evt_out`=8'h88 then 8'h90 (count 2, head code 0). After one ack, `evt_out`=8'h8B (count 1, head code 3).
- Overflow: five distinct presses with no ack -> count 4, fifth dropped, `evt_out`=8'hE0|head (valid, overflow, count 4). One ack -> overflow cleared, count 3. Also a push in the same cycle as that pop keeps count 4 with overflow=0.
- Empty pop: `ack` rising edge with empty FIFO -> state unchanged and no pointer corruption. A subsequent press reads back the correct code.
